slc3_control_seq: RTL and testbench

Control sequencer for the SLC-3 datapath. A Moore state machine that steps through fetch, decode and execute. Each cycle it drives every register load enable, bus gate, mux select and ALU function used by the datapath, plus the active-low SRAM strobes. Memory-access states are stretched by a programmable wait counter.

---
 rtl/slc3_control_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_slc3_control_seq.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slc3_control_seq.sv
// slc3_control_seq: Moore control sequencer for the SLC-3 datapath.
// Steps fetch / decode / execute and drives every load, gate, mux select,
// ALU function and the active-low SRAM strobes from the current state.
// Memory-access states (S33, S25, S16) are held for MEM_WAIT cycles.
// Optional feature macro: SLC3_PAUSE_EN (opcode 1101 enters a Continue
// handshake and pulses LD_LED); when undefined, 1101 is a NOP.
module slc3_control_seq #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic       ADDR1MUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_WAIT - 1);

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32,
        S01, S05, S09, S00, S22, S12, S04, S21,
        S06, S25, S27, S07, S23, S16
`ifdef SLC3_PAUSE_EN
        , PAUSE_IR1, PAUSE_IR2
`endif
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             led_first, led_first_n;

`ifndef SLC3_PAUSE_EN
    logic unused_continue;
    assign unused_continue = Continue;
`endif

    // State, wait counter and LED first-cycle flag; reset wins over everything
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= HALTED;
            cnt       <= '0;
            led_first <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            led_first <= led_first_n;
        end
    end

    // Next-state, wait-counter update and Moore output decode
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        led_first_n = 1'b0;
        LD_MAR      = 1'b0;
        LD_MDR      = 1'b0;
        LD_IR       = 1'b0;
        LD_BEN      = 1'b0;
        LD_CC       = 1'b0;
        LD_REG      = 1'b0;
        LD_PC       = 1'b0;
        LD_LED      = 1'b0;
        GatePC      = 1'b0;
        GateMDR     = 1'b0;
        GateALU     = 1'b0;
        GateMARMUX  = 1'b0;
        PCMUX       = 2'd0;
        ADDR2MUX    = 2'd0;
        ADDR1MUX    = 1'b0;
        DRMUX       = 1'b0;
        SR1MUX      = 1'b0;
        SR2MUX      = 1'b0;
        ALUK        = 2'd0;
        MIO_EN      = 1'b0;
        Mem_OE      = 1'b1;
        Mem_WE      = 1'b1;

        case (state)
            HALTED: begin
                if (Run) state_n = S18;
            end
            S18: begin
                GatePC  = 1'b1;
                LD_MAR  = 1'b1;
                PCMUX   = 2'd2;
                LD_PC   = 1'b1;
                state_n = S33;
                cnt_n   = WAIT_LOAD;
            end
            S33, S25: begin
                Mem_OE = 1'b0;
                MIO_EN = 1'b1;
                LD_MDR = 1'b1;
                if (cnt == '0) state_n = (state == S33) ? S35 : S27;
                else           cnt_n   = cnt - CNT_W'(1);
            end
            S35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                state_n = S32;
            end
            S32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    4'b0001: state_n = S01;
                    4'b0101: state_n = S05;
                    4'b1001: state_n = S09;
                    4'b0000: state_n = S00;
                    4'b1100: state_n = S12;
                    4'b0100: state_n = S04;
                    4'b0110: state_n = S06;
                    4'b0111: state_n = S07;
`ifdef SLC3_PAUSE_EN
                    4'b1101: begin
                        state_n     = PAUSE_IR1;
                        led_first_n = 1'b1;
                    end
`endif
                    default: state_n = S18;
                endcase
            end
            S01, S05: begin
                SR1MUX  = 1'b1;
                SR2MUX  = IR_5 ? 1'b1 : 1'b0;
                ALUK    = (state == S05) ? 2'd1 : 2'd0;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_n = S18;
            end
            S09: begin
                SR1MUX  = 1'b1;
                ALUK    = 2'd2;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_n = S18;
            end
            S00: begin
                state_n = BEN ? S22 : S18;
            end
            S22: begin
                ADDR2MUX = 2'd2;
                PCMUX    = 2'd1;
                LD_PC    = 1'b1;
                state_n  = S18;
            end
            S12: begin
                SR1MUX  = 1'b1;
                ALUK    = 2'd3;
                GateALU = 1'b1;
                LD_PC   = 1'b1;
                state_n = S18;
            end
            S04: begin
                GatePC  = 1'b1;
                DRMUX   = 1'b1;
                LD_REG  = 1'b1;
                state_n = S21;
            end
            S21: begin
                ADDR2MUX = 2'd3;
                PCMUX    = 2'd1;
                LD_PC    = 1'b1;
                state_n  = S18;
            end
            S06, S07: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'd1;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_n    = (state == S06) ? S25 : S23;
                if (state == S06) cnt_n = WAIT_LOAD;
            end
            S27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_n = S18;
            end
            S23: begin
                ALUK    = 2'd3;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                state_n = S16;
                cnt_n   = WAIT_LOAD;
            end
            S16: begin
                Mem_WE = 1'b0;
                if (cnt == '0) state_n = S18;
                else           cnt_n   = cnt - CNT_W'(1);
            end
`ifdef SLC3_PAUSE_EN
            PAUSE_IR1: begin
                LD_LED = led_first;
                if (Continue) state_n = PAUSE_IR2;
            end
            PAUSE_IR2: begin
                if (!Continue) state_n = S18;
            end
`endif
            default: state_n = HALTED;
        endcase
    end

endmodule

// File: tb/tb_slc3_control_seq.sv
// tb_slc3_control_seq: three sequencers (MEM_WAIT = 1, 2, 3) share one
// stimulus; each is compared cycle by cycle with an instruction-level
// expectation list built from the per-state output table.
module tb_slc3_control_seq;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic [1:0] addr2mux;
        logic       addr1mux, drmux, sr1mux, sr2mux;
        logic [1:0] aluk;
        logic       mio_en, mem_oe, mem_we;
    } ctl_t;
    typedef ctl_t cq_t[$];

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic       Continue = 1'b0;
    logic [3:0] Opcode = 4'd0;
    logic       IR_5 = 1'b0;
    logic       BEN = 1'b0;

    ctl_t obs [3];
    cq_t  exp [3];
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux, addr2mux, aluk;
        logic addr1mux, drmux, sr1mux, sr2mux, mio_en, mem_oe, mem_we;
        slc3_control_seq #(.MEM_WAIT(g + 1)) u_dut (
            .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
            .Opcode(Opcode), .IR_5(IR_5), .BEN(BEN),
            .LD_MAR(ld_mar), .LD_MDR(ld_mdr), .LD_IR(ld_ir), .LD_BEN(ld_ben),
            .LD_CC(ld_cc), .LD_REG(ld_reg), .LD_PC(ld_pc), .LD_LED(ld_led),
            .GatePC(gate_pc), .GateMDR(gate_mdr), .GateALU(gate_alu),
            .GateMARMUX(gate_marmux), .PCMUX(pcmux), .ADDR2MUX(addr2mux),
            .ADDR1MUX(addr1mux), .DRMUX(drmux), .SR1MUX(sr1mux), .SR2MUX(sr2mux),
            .ALUK(aluk), .MIO_EN(mio_en), .Mem_OE(mem_oe), .Mem_WE(mem_we)
        );
        assign obs[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
                         gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux, addr2mux,
                         addr1mux, drmux, sr1mux, sr2mux, aluk, mio_en, mem_oe, mem_we};
    end

    function automatic ctl_t def_ctl();
        ctl_t w;
        w        = '0;
        w.mem_oe = 1'b1;
        w.mem_we = 1'b1;
        return w;
    endfunction

    function automatic ctl_t fetch_ctl();
        ctl_t w;
        w         = def_ctl();
        w.gate_pc = 1'b1;
        w.ld_mar  = 1'b1;
        w.pcmux   = 2'd2;
        w.ld_pc   = 1'b1;
        return w;
    endfunction

    function automatic ctl_t read_ctl();
        ctl_t w;
        w        = def_ctl();
        w.mem_oe = 1'b0;
        w.mio_en = 1'b1;
        w.ld_mdr = 1'b1;
        return w;
    endfunction

    // Expected output words for a program that repeats one instruction
    // (inputs held constant), starting at the first cycle after Run.
    task automatic build(input int mw, input logic [3:0] opc, input logic ir5,
                         input logic ben, input int n, output cq_t q);
        ctl_t w;
        bit   parked;
        parked = 1'b0;
        q = {};
        while (q.size() < n) begin
            if (parked) begin
                q.push_back(def_ctl());
            end else begin
                q.push_back(fetch_ctl());
                repeat (mw) q.push_back(read_ctl());
                w = def_ctl(); w.gate_mdr = 1'b1; w.ld_ir = 1'b1; q.push_back(w);
                w = def_ctl(); w.ld_ben = 1'b1; q.push_back(w);
                w = def_ctl();
                case (opc)
                    4'b0001, 4'b0101, 4'b1001: begin
                        w.sr1mux = 1'b1;
                        w.sr2mux = (opc == 4'b1001) ? 1'b0 : ir5;
                        w.aluk = (opc == 4'b0001) ? 2'd0 : (opc == 4'b0101) ? 2'd1 : 2'd2;
                        w.gate_alu = 1'b1; w.ld_reg = 1'b1; w.ld_cc = 1'b1;
                        q.push_back(w);
                    end
                    4'b0000: begin
                        q.push_back(w);
                        if (ben) begin
                            w.addr2mux = 2'd2; w.pcmux = 2'd1; w.ld_pc = 1'b1;
                            q.push_back(w);
                        end
                    end
                    4'b1100: begin
                        w.sr1mux = 1'b1; w.aluk = 2'd3; w.gate_alu = 1'b1; w.ld_pc = 1'b1;
                        q.push_back(w);
                    end
                    4'b0100: begin
                        w.gate_pc = 1'b1; w.drmux = 1'b1; w.ld_reg = 1'b1;
                        q.push_back(w);
                        w = def_ctl(); w.addr2mux = 2'd3; w.pcmux = 2'd1; w.ld_pc = 1'b1;
                        q.push_back(w);
                    end
                    4'b0110, 4'b0111: begin
                        w.sr1mux = 1'b1; w.addr1mux = 1'b1; w.addr2mux = 2'd1;
                        w.gate_marmux = 1'b1; w.ld_mar = 1'b1;
                        q.push_back(w);
                        if (opc == 4'b0110) begin
                            repeat (mw) q.push_back(read_ctl());
                            w = def_ctl(); w.gate_mdr = 1'b1; w.ld_reg = 1'b1; w.ld_cc = 1'b1;
                            q.push_back(w);
                        end else begin
                            w = def_ctl(); w.aluk = 2'd3; w.gate_alu = 1'b1; w.ld_mdr = 1'b1;
                            q.push_back(w);
                            w = def_ctl(); w.mem_we = 1'b0;
                            repeat (mw) q.push_back(w);
                        end
                    end
`ifdef SLC3_PAUSE_EN
                    4'b1101: begin
                        w.ld_led = 1'b1;
                        q.push_back(w);
                        parked = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    endtask

    // Reset the DUTs, present an instruction and raise Run (stimulus only)
    task automatic start_prog(input logic [3:0] opc, input logic ir5, input logic ben,
                              input int n);
        Reset = 1'b1;
        Run   = 1'b0;
        @(posedge Clk); #1;
        Reset  = 1'b0;
        Opcode = opc;
        IR_5   = ir5;
        BEN    = ben;
        Run    = 1'b1;
        for (int g = 0; g < 3; g++) build(g + 1, opc, ir5, ben, n, exp[g]);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Run   = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (obs[g] !== def_ctl()) begin
                errors++;
                $display("FAIL reset mw=%0d got=%h exp=%h", g + 1, obs[g], def_ctl());
            end
        end
        Run   = 1'b0;
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk); #1;
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs[g] !== def_ctl()) begin
                    errors++;
                    $display("FAIL halted_idle mw=%0d cyc=%0d got=%h exp=%h",
                             g + 1, c, obs[g], def_ctl());
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        start_prog(4'b0001, 1'b1, 1'b0, 3);
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk); #1;
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs[g] !== exp[g][c]) begin
                    errors++;
                    $display("FAIL pre_reset mw=%0d cyc=%0d got=%h exp=%h",
                             g + 1, c, obs[g], exp[g][c]);
                end
            end
        end
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (obs[g] !== def_ctl()) begin
                errors++;
                $display("FAIL reset_mid_wait mw=%0d got=%h exp=%h", g + 1, obs[g], def_ctl());
            end
            build(g + 1, 4'b0001, 1'b1, 1'b0, 8, exp[g]);
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge Clk); #1;
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs[g] !== exp[g][c]) begin
                    errors++;
                    $display("FAIL restart mw=%0d cyc=%0d got=%h exp=%h",
                             g + 1, c, obs[g], exp[g][c]);
                end
            end
        end
    endtask

    task automatic test_add();
        start_prog(4'b0001, 1'b1, 1'b0, 14);
        for (int c = 0; c < 14; c++) begin
            @(posedge Clk); #1;
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs[g] !== exp[g][c]) begin
                    errors++;
                    $display("FAIL add mw=%0d cyc=%0d got=%h exp=%h",
                             g + 1, c, obs[g], exp[g][c]);
                end
            end
        end
    endtask

    task automatic test_br();
        for (int b = 1; b >= 0; b--) begin
            start_prog(4'b0000, 1'b0, 1'(b), 16);
            for (int c = 0; c < 16; c++) begin
                @(posedge Clk); #1;
                for (int g = 0; g < 3; g++) begin
                    checks++;
                    if (obs[g] !== exp[g][c]) begin
                        errors++;
                        $display("FAIL br ben=%0d mw=%0d cyc=%0d got=%h exp=%h",
                                 b, g + 1, c, obs[g], exp[g][c]);
                    end
                end
            end
        end
    endtask

    task automatic test_str();
        int we_low [3];
        start_prog(4'b0111, 1'b0, 1'b0, 16);
        for (int g = 0; g < 3; g++) we_low[g] = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge Clk); #1;
            for (int g = 0; g < 3; g++) begin
                if (!obs[g].mem_we) we_low[g]++;
                checks++;
                if (obs[g] !== exp[g][c]) begin
                    errors++;
                    $display("FAIL str mw=%0d cyc=%0d got=%h exp=%h",
                             g + 1, c, obs[g], exp[g][c]);
                end
            end
        end
        // MEM_WAIT=2 copy: 16 cycles hold exactly one STR (9 cycles) plus a partial refetch
        checks++;
        if (we_low[1] !== 2) begin
            errors++;
            $display("FAIL str_we_cycles mw=2 got=%0d exp=2", we_low[1]);
        end
    endtask

    task automatic test_unused();
        start_prog(4'b1010, 1'b1, 1'b1, 12);
        for (int c = 0; c < 12; c++) begin
            @(posedge Clk); #1;
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs[g] !== exp[g][c]) begin
                    errors++;
                    $display("FAIL unused_op mw=%0d cyc=%0d got=%h exp=%h",
                             g + 1, c, obs[g], exp[g][c]);
                end
            end
        end
    endtask

    task automatic test_pause();
        int leds [3];
        Continue = 1'b0;
        start_prog(4'b1101, 1'b0, 1'b0, 25);
        for (int g = 0; g < 3; g++) leds[g] = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge Clk); #1;
            for (int g = 0; g < 3; g++) begin
                if (obs[g].ld_led) leds[g]++;
                checks++;
                if (obs[g] !== exp[g][c]) begin
                    errors++;
                    $display("FAIL pause_hold mw=%0d cyc=%0d got=%h exp=%h",
                             g + 1, c, obs[g], exp[g][c]);
                end
            end
        end
`ifdef SLC3_PAUSE_EN
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (leds[g] !== 1) begin
                errors++;
                $display("FAIL led_pulses mw=%0d got=%0d exp=1", g + 1, leds[g]);
            end
        end
        Continue = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk); #1;
            for (int g = 0; g < 3; g++) begin
                checks++;
                if (obs[g] !== def_ctl()) begin
                    errors++;
                    $display("FAIL pause_cont mw=%0d cyc=%0d got=%h exp=%h",
                             g + 1, c, obs[g], def_ctl());
                end
            end
        end
        Continue = 1'b0;
        @(posedge Clk); #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (obs[g] !== fetch_ctl()) begin
                errors++;
                $display("FAIL pause_resume mw=%0d got=%h exp=%h", g + 1, obs[g], fetch_ctl());
            end
        end
        @(posedge Clk); #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (obs[g] !== read_ctl()) begin
                errors++;
                $display("FAIL pause_refetch mw=%0d got=%h exp=%h", g + 1, obs[g], read_ctl());
            end
        end
`else
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (leds[g] !== 0) begin
                errors++;
                $display("FAIL led_pulses mw=%0d got=%0d exp=0", g + 1, leds[g]);
            end
        end
`endif
    endtask

    // Random programs; Run is toggled mid-instruction and must be ignored
    task automatic test_random();
        logic [3:0] opc;
        logic       ir5, ben;
        for (int t = 0; t < 40; t++) begin
            opc      = 4'($urandom_range(0, 15));
            ir5      = 1'($urandom_range(0, 1));
            ben      = 1'($urandom_range(0, 1));
            Continue = 1'($urandom_range(0, 1));
            start_prog(opc, ir5, ben, 24);
            for (int c = 0; c < 24; c++) begin
                @(posedge Clk); #1;
                Run = 1'($urandom_range(0, 1));
                for (int g = 0; g < 3; g++) begin
                    checks++;
                    if (obs[g] !== exp[g][c]) begin
                        errors++;
                        $display("FAIL random op=%b mw=%0d cyc=%0d got=%h exp=%h",
                                 opc, g + 1, c, obs[g], exp[g][c]);
                    end
                end
            end
        end
        Continue = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_add();
        test_br();
        test_str();
        test_unused();
        test_pause();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
